// File: rtl/spi_word_capture_pkg.sv
// Shared definitions for the serial word capture block: FSM encoding and
// the bit-counter width helper.
package spi_word_capture_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_END   = 2'd2;

  // Counter holds 0..WORD_BITS-1; keep at least one bit for tiny words.
  function automatic int cnt_width(input int word_bits);
    return (word_bits < 2) ? 1 : $clog2(word_bits);
  endfunction

endpackage

// File: rtl/spi_word_capture_shift_reg_in.sv
// Serial-in / parallel-out shift register with selectable bit order.
// par_o is the look-ahead value, so a word completing this cycle is visible now.
module shift_reg_in #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             din,
  output logic [WIDTH-1:0] par_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] shifted;

  // MSB-first enters at bit 0 and moves up; LSB-first enters at the top and moves down.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {sr_q[WIDTH-2:0], din};
    end else begin : g_lsb
      assign shifted = {din, sr_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    par_o = sr_q;
    if (clear)         par_o = '0;
    else if (shift_en) par_o = shifted;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= par_o;
  end

endmodule

// File: rtl/spi_word_capture.sv
// Assembles sampled serial bits into words inside a chip-select frame and
// hands them out through a one-word valid/ready buffer.
module spi_word_capture
  import spi_word_capture_pkg::*;
#(
  parameter int WORD_BITS = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 sample_pulse,
  input  logic                 ser_data,
  input  logic                 frame_n,
  output logic [WORD_BITS-1:0] word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 frame_active,
  output logic                 frame_done,
  output logic                 truncated,
  output logic                 overflow
);

  localparam int CW = cnt_width(WORD_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_BITS - 1);

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_BITS-1:0] buf_q, buf_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;

  logic                 start, clr, shift_en, complete;
  logic [WORD_BITS-1:0] word_next;

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    clr      = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!frame_n) begin
          state_d = ST_SHIFT;
          start   = 1'b1;
          clr     = 1'b1;
        end
      end
      ST_SHIFT: begin
        // Frame end wins over a coincident sample strobe.
        if (frame_n)           state_d  = ST_END;
        else if (sample_pulse) shift_en = 1'b1;
      end
      ST_END: begin
        state_d = ST_IDLE;
        clr     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign complete = shift_en && (cnt_q == LAST_BIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)           cnt_d = '0;
    else if (complete) cnt_d = '0;
    else if (shift_en) cnt_d = cnt_q + CW'(1);
  end

  shift_reg_in #(
    .WIDTH     (WORD_BITS),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk      (sys_clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .clear    (clr),
    .din      (ser_data),
    .par_o    (word_next)
  );

  // The buffer runs independently of the FSM; a held word survives frame edges.
  always_comb begin
    buf_d   = buf_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (complete) begin
      if (!valid_q || word_ready) begin
        buf_d   = word_next;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
    if (start) ovf_d = 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign word_out     = buf_q;
  assign word_valid   = valid_q;
  assign overflow     = ovf_q;
  assign frame_active = (state_q == ST_SHIFT);
  assign frame_done   = (state_q == ST_END);
  assign truncated    = (state_q == ST_END) && (cnt_q != '0);

endmodule

// File: tb/tb_spi_word_capture.sv
// Bench for spi_word_capture: one MSB-first and one LSB-first instance share
// stimulus; directed vectors plus random traffic against a frame-level model.
module tb_spi_word_capture;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, sample_pulse, ser_data, frame_n, word_ready;
  logic [W-1:0] m_word, l_word;
  logic         m_valid, m_act, m_done, m_trunc, m_ovf;
  logic         l_valid, l_act, l_done, l_trunc, l_ovf;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  spi_word_capture #(.WORD_BITS(W), .MSB_FIRST(1'b1)) u_msb (
    .sys_clk(clk), .rst_n(rst_n), .sample_pulse(sample_pulse), .ser_data(ser_data),
    .frame_n(frame_n), .word_out(m_word), .word_valid(m_valid), .word_ready(word_ready),
    .frame_active(m_act), .frame_done(m_done), .truncated(m_trunc), .overflow(m_ovf));

  spi_word_capture #(.WORD_BITS(W), .MSB_FIRST(1'b0)) u_lsb (
    .sys_clk(clk), .rst_n(rst_n), .sample_pulse(sample_pulse), .ser_data(ser_data),
    .frame_n(frame_n), .word_out(l_word), .word_valid(l_valid), .word_ready(word_ready),
    .frame_active(l_act), .frame_done(l_done), .truncated(l_trunc), .overflow(l_ovf));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Reference model: phase 0 idle, 1 in frame, 2 frame-end cycle; bits of the
  // current word are kept as a queue in arrival order.
  int           ph = 0;
  bit           bq[$];
  logic [W-1:0] mb = '0, lb = '0;
  logic         mv = 1'b0, mo = 1'b0;

  task automatic model_step(input logic r, p, d, f, y);
    logic         comp;
    logic [W-1:0] wm, wl;
    comp = 1'b0; wm = '0; wl = '0;
    if (!r) begin
      ph = 0; bq.delete(); mb = '0; lb = '0; mv = 1'b0; mo = 1'b0;
      return;
    end
    case (ph)
      0: if (!f) begin ph = 1; bq.delete(); mo = 1'b0; end
      1: begin
        if (f) ph = 2;
        else if (p) begin
          bq.push_back(d);
          if (bq.size() == W) begin
            comp = 1'b1;
            for (int i = 0; i < W; i++) begin
              wm[W-1-i] = bq[i];
              wl[i]     = bq[i];
            end
            bq.delete();
          end
        end
      end
      default: begin ph = 0; bq.delete(); end
    endcase
    if (comp) begin
      if (!mv || y) begin mb = wm; lb = wl; mv = 1'b1; end
      else mo = 1'b1;
    end else if (mv && y) begin
      mv = 1'b0;
    end
  endtask

  task automatic model_cmp();
    logic e_trunc;
    e_trunc = (ph == 2) && (bq.size() != 0);
    chk("m_valid", m_valid, mv);       chk("l_valid", l_valid, mv);
    chk("m_word", m_word, mb);         chk("l_word", l_word, lb);
    chk("m_active", m_act, ph == 1);   chk("l_active", l_act, ph == 1);
    chk("m_done", m_done, ph == 2);    chk("l_done", l_done, ph == 2);
    chk("m_trunc", m_trunc, e_trunc);  chk("l_trunc", l_trunc, e_trunc);
    chk("m_ovf", m_ovf, mo);           chk("l_ovf", l_ovf, mo);
  endtask

  task automatic cyc(input logic r, p, d, f, y);
    @(negedge clk);
    rst_n = r; sample_pulse = p; ser_data = d; frame_n = f; word_ready = y;
    @(posedge clk);
    model_step(r, p, d, f, y);
    #1;
    model_cmp();
  endtask

  task automatic send_bits(input logic [7:0] v, input int n, input logic y);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, v[7-i], 1'b0, y);
  endtask

  typedef struct {
    logic p, d, f, y;
    logic e_act, e_vld, e_done, e_trunc;
    logic [7:0] e_word;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{1'b1, a5[8-i], 1'b0, 1'b1, 1'b1, (i == 8), 1'b0, 1'b0, 8'hA5};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    rst_n = 1'b0; sample_pulse = 1'b0; ser_data = 1'b0; frame_n = 1'b1; word_ready = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_word", m_word, 8'h00);
    chk("rst_ovf", m_ovf, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Basic MSB-first word
    for (int i = 0; i < 11; i++) begin
      cyc(1'b1, tbl[i].p, tbl[i].d, tbl[i].f, tbl[i].y);
      chk($sformatf("tbl%0d_act", i), m_act, tbl[i].e_act);
      chk($sformatf("tbl%0d_vld", i), m_valid, tbl[i].e_vld);
      chk($sformatf("tbl%0d_done", i), m_done, tbl[i].e_done);
      chk($sformatf("tbl%0d_trunc", i), m_trunc, tbl[i].e_trunc);
      if (tbl[i].e_vld) chk($sformatf("tbl%0d_word", i), m_word, tbl[i].e_word);
    end

    // Pulses outside a frame are ignored
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'(i), 1'b1, 1'b1);
    chk("ign_vld", m_valid, 1'b0);
    chk("ign_act", m_act, 1'b0);

    // LSB-first: bits 1,1,0,0,0,0,0,0
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(8'hC0, 8, 1'b1);
    chk("lsb_word", l_word, 8'h03);
    chk("lsb_vld", l_valid, 1'b1);
    chk("lsb_msb_word", m_word, 8'hC0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Backpressure and overflow
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'h3C, 8, 1'b0);
    chk("bp_word1", m_word, 8'h3C);
    chk("bp_ovf0", m_ovf, 1'b0);
    send_bits(8'hC3, 8, 1'b0);
    chk("bp_word_kept", m_word, 8'h3C);
    chk("bp_ovf1", m_ovf, 1'b1);
    chk("bp_vld", m_valid, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_done", m_done, 1'b1);
    chk("bp_ovf_end", m_ovf, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("bp_consumed", m_valid, 1'b0);
    chk("bp_ovf_idle", m_ovf, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_ovf_cleared", m_ovf, 1'b0);

    // Completion coinciding with a handshake on the old word
    send_bits(8'h11, 8, 1'b0);
    chk("sim_old", m_word, 8'h11);
    send_bits(8'h5A, 7, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("sim_word", m_word, 8'h5A);
    chk("sim_vld", m_valid, 1'b1);
    chk("sim_ovf", m_ovf, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sim_consumed", m_valid, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Truncated frame followed by a full one
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(8'hF8, 5, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("tr_done", m_done, 1'b1);
    chk("tr_trunc", m_trunc, 1'b1);
    chk("tr_vld", m_valid, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("tr_done_pulse", m_done, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(8'hFF, 8, 1'b1);
    chk("tr_full_word", m_word, 8'hFF);
    chk("tr_full_vld", m_valid, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset mid-frame with a word held in the buffer
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'h96, 8, 1'b0);
    send_bits(8'h96, 4, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mr_vld", m_valid, 1'b0);
    chk("mr_word", m_word, 8'h00);
    chk("mr_act", m_act, 1'b0);
    chk("mr_lword", l_word, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic r, f;
      r = ($urandom_range(0, 299) != 0);
      f = frame_n;
      if ($urandom_range(0, 24) == 0) f = ~f;
      cyc(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f,
          1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
